// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder/subtractor that processes one CHUNK-bit slice per clock.
//
// Parameters
//   WIDTH  operand/result width in bits (must be a multiple of CHUNK)
//   CHUNK  bits added per cycle; NCH = WIDTH/CHUNK cycles per operation
//
// Ports
//   clk    clock; all logic on the rising edge
//   rst_n  synchronous active-low reset
//   start  begin an operation (accepted in IDLE or DONE, ignored while busy)
//   a, b   operands, captured on acceptance
//   cin    carry-in for add mode (ignored in subtract mode)
//   sub    0 = a + b + cin, 1 = a - b (cout = 1 means no borrow)
//   busy   high while slices are being added
//   done   one-cycle pulse; sum/cout (and ovf) updated at the same edge
//   sum    result, held until the next done
//   cout   carry out of bit WIDTH-1
//   ovf    signed overflow of the result (only with CHUNK_ADDER_OVF_EN defined)
//
// Build option: define CHUNK_ADDER_OVF_EN to add the ovf output and its logic.

module chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;       // already inverted for subtract
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  res_q, res_d;   // partial result being assembled
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef CHUNK_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
  logic              slice_ovf;
`endif

  logic              accept;
  logic              last_slice;
  logic [31:0]       base;
  logic [CHUNK-1:0]  a_sl, b_sl;
  logic [CHUNK:0]    slice_sum;

  assign accept     = start && (state_q != StRun);
  assign last_slice = (state_q == StRun) && (idx_q == IdxW'(NCH - 1));

  // Current slice adder
  always_comb begin
    base      = 32'(idx_q) * CHUNK;
    a_sl      = a_q[base +: CHUNK];
    b_sl      = b_q[base +: CHUNK];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

`ifdef CHUNK_ADDER_OVF_EN
  // Same-sign operands producing an opposite-sign MSB: carry into MSB != carry out.
  assign slice_ovf = (a_sl[CHUNK-1] == b_sl[CHUNK-1]) &&
                     (slice_sum[CHUNK-1] != a_sl[CHUNK-1]);
`endif

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CHUNK_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CHUNK_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CHUNK_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      idx_d   = '0;
      a_d     = a;
      // Subtract as a + ~b + 1; cin is ignored in that mode.
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      res_d   = '0;
    end else if (state_q == StRun) begin
      res_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
      carry_d              = slice_sum[CHUNK];
      if (last_slice) begin
        idx_d  = '0;
        sum_d  = res_d;
        cout_d = slice_sum[CHUNK];
`ifdef CHUNK_ADDER_OVF_EN
        ovf_d  = slice_ovf;
`endif
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
`ifdef CHUNK_ADDER_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in for add mode.
REQ-009 The block SHALL have port sub, input, 1 bit: mode select, 0 = add, 1 = subtract.
REQ-010 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The block SHALL have port sum, output, WIDTH bits: result.
REQ-013 The block SHALL have port cout, output, 1 bit: carry out of the MSB.

Function
REQ-014 The block SHALL be controlled by an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE with start=1, the block SHALL capture a, b, cin and sub into internal registers, clear the chunk index, and go to RUN.
REQ-016 In RUN, the block SHALL add one CHUNK-bit slice per cycle, LSB slice first, and carry the registered carry into the next slice.
REQ-017 After slice NCH-1, the block SHALL go to DONE; DONE SHALL last exactly one cycle, then return to IDLE unless start=1 in that cycle.
REQ-018 Latency: if start is accepted at edge t, done SHALL be 1 for exactly the cycle after edge t+NCH, i.e. NCH+1 cycles after acceptance.
REQ-019 busy SHALL be 1 exactly while the state is RUN.
REQ-020 In add mode, the result SHALL be sum = (a + b + cin) mod 2^WIDTH, with cout the carry out of bit WIDTH-1.
REQ-021 In subtract mode, the result SHALL be a + ~b + 1; cin SHALL be ignored, and cout=1 SHALL mean no borrow (a >= b unsigned).
REQ-022 sum and cout SHALL update only when done rises, and SHALL hold their values until the next done.
REQ-023 While busy=1, start SHALL be ignored, and changes on a, b, cin or sub SHALL NOT affect the result in progress.
REQ-024 A start in the DONE cycle SHALL be accepted, giving back-to-back operations every NCH+1 cycles.
REQ-025 A carry generated in slice 0 SHALL propagate correctly through all slices (full wrap case, e.g. FFFF+1).

Reset
REQ-026 When rst_n=0 at a clock edge, the state SHALL go to IDLE, and busy, done, sum, cout and the chunk index SHALL be cleared to 0.
REQ-027 Reset SHALL take priority over start and over any operation in progress; an aborted operation SHALL produce no done pulse.
REQ-028 start SHALL be ignored in any cycle where rst_n=0.

Configuration
REQ-029 With macro CHUNK_ADDER_OVF_EN defined, the block SHALL add output ovf, 1 bit: signed two's-complement overflow of the MSB slice (carry into MSB XOR carry out).
REQ-030 ovf SHALL update and hold with the same timing as sum, and SHALL reset to 0.
REQ-031 Without CHUNK_ADDER_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=16, CHUNK=4)
REQ-032 Basic add: a=1234h, b=4321h, cin=0, sub=0, start at cycle 0 -> done=1 in cycle 5 only, sum=5555h, cout=0, busy=1 in cycles 1-4.
REQ-033 Full carry ripple: a=FFFFh, b=0001h, cin=0 -> sum=0000h, cout=1; with OVF_EN, ovf=0.
REQ-034 Subtract: a=0005h, b=0007h, sub=1, cin=1 -> sum=FFFEh, cout=0 (cin ignored); then a=0007h, b=0005h -> sum=0002h, cout=1.
REQ-035 Signed overflow (OVF_EN): a=7FFFh, b=0001h -> sum=8000h, ovf=1; a=8000h, b=7FFFh, cin=1 -> sum=0000h, cout=1, ovf=0.
REQ-036 Back-to-back and busy-start: a new start in the DONE cycle -> second done exactly 5 cycles later; a start pulse and operand changes during RUN -> no effect on the result.
REQ-037 Reset mid-operation: rst_n=0 in cycle 2 of RUN -> no done pulse, and all outputs are 0 on the next cycle; the next operation is correct.
